// File: rtl/ct_loader.sv
// rtl/ct_loader.sv - length-prefixed ciphertext stream loader into ct_mem, starts the cracker
module ct_loader #(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [7:0]        ct_wrdata,
  output logic              ct_wren,
  output logic              crack_en,
  input  logic              crack_rdy,
  output logic [7:0]        msg_len,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_START,
    S_WAIT,
    S_ERROR
  } state_t;

  // 9-bit so that an 8-bit length of 255 compares correctly against any MAX_LEN.
  localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // address of the next message byte
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                wren_q, wren_d;
  logic                crack_en_q, crack_en_d;
  logic [7:0]          msg_len_q, msg_len_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   len_a;                // latched length as an address

  assign len_a     = ADDR_W'(msg_len_q);
  assign ct_addr   = wr_addr_q;
  assign ct_wrdata = wr_data_q;
  assign ct_wren   = wren_q;
  assign crack_en  = crack_en_q;
  assign msg_len   = msg_len_q;
  assign err       = err_q;

  // State register and registered write port / status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wren_q     <= 1'b0;
      crack_en_q <= 1'b0;
      msg_len_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wren_q     <= wren_d;
      crack_en_q <= crack_en_d;
      msg_len_q  <= msg_len_d;
      err_q      <= err_d;
    end
  end

  // Next-state, handshake outputs and the write generated by each accepted beat.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wren_d     = 1'b0;
    crack_en_d = 1'b0;
    msg_len_d  = msg_len_q;
    err_d      = err_q;
    rdy        = 1'b0;
    in_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d = S_LEN;
          err_d   = 1'b0;
        end
      end

      S_LEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wren_d    = 1'b1;
          wr_addr_d = '0;
          wr_data_d = in_data;
          msg_len_d = in_data;
          addr_d    = ADDR_W'(1);
          if ({1'b0, in_data} > MAX_LEN_C) begin
            state_d = S_ERROR;
          end else if (in_data == 8'd0) begin
            state_d = in_last ? S_START : S_ERROR;
          end else if (in_last) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wren_d    = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          if (addr_q == len_a) begin
            // Final expected byte: in_last must coincide with it.
            state_d = in_last ? S_START : S_ERROR;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (in_last) begin
              state_d = S_ERROR;
            end
          end
        end
      end

      S_START: begin
        if (crack_rdy) begin
          crack_en_d = 1'b1;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // Only return to idle once the cracker has dropped rdy, so a stale
        // rdy from before the start pulse is never mistaken for completion.
        if (!crack_rdy) begin
          state_d = S_IDLE;
        end
      end

      S_ERROR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_ERROR) begin
      err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_loader.sv
// tb/tb_ct_loader.sv - directed self-checking bench for ct_loader
module tb_ct_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rdy;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;
  logic       crack_en;
  logic       crack_rdy;
  logic [7:0] msg_len;
  logic       err;

  bit hold = 1'b0;
  bit busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int wr_a[$];
  int wr_d[$];
  int wr_c[$];
  int ce_c[$];

  logic [7:0] beats [0:7];

  ct_loader #(.ADDR_W(8), .MAX_LEN(255)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .crack_en(crack_en), .crack_rdy(crack_rdy), .msg_len(msg_len), .err(err)
  );

  always #5 clk = ~clk;

  // Cracker model: drops rdy for one cycle after seeing the start pulse.
  assign crack_rdy = !hold && !busy;
  always @(posedge clk) busy <= crack_en;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and start pulse with the cycle it was visible in.
  always @(negedge clk) begin
    if (ct_wren === 1'b1) begin
      wr_a.push_back(int'(ct_addr));
      wr_d.push_back(int'(ct_wrdata));
      wr_c.push_back(cyc);
    end
    if (crack_en === 1'b1) ce_c.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wr_a.delete(); wr_d.delete(); wr_c.delete(); ce_c.delete();
  endtask

  task automatic do_en();
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l, output bit acc, output int pc);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    acc = in_ready;
    pc  = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic stream(input int n, input int last_idx, input bit gap, output int p0, output int n_acc);
    bit acc;
    int pc;
    n_acc = 0;
    p0 = 0;
    for (int i = 0; i < n; i++) begin
      drive_beat(beats[i], (i == last_idx), acc, pc);
      if (i == 0) p0 = pc;
      if (!acc) break;
      n_acc++;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) break;
    end
    check_eq({tag, "_settle_rdy"}, rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_writes(input string tag, input int n, input int p0, input int stride);
    check_eq({tag, "_nwr"}, wr_a.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_a.size()) begin
        check_eq({tag, "_addr"}, wr_a[i], i);
        check_eq({tag, "_data"}, wr_d[i], beats[i]);
        if (stride > 0) check_eq({tag, "_wcyc"}, wr_c[i], p0 + 1 + stride * i);
      end
    end
  endtask

  initial begin
    int p0, na, k;
    bit acc;
    int pc;

    // Reset values while rst is held.
    @(negedge clk); @(negedge clk);
    check_eq("rst_rdy", rdy, 1);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_wren", ct_wren, 0);
    check_eq("rst_addr", ct_addr, 0);
    check_eq("rst_wrdata", ct_wrdata, 0);
    check_eq("rst_crack_en", crack_en, 0);
    check_eq("rst_msg_len", msg_len, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean 3-byte load.
    clr();
    do_en();
    check_eq("t1_rdy_low", rdy, 0);
    beats[0] = 8'h03; beats[1] = 8'hA1; beats[2] = 8'hB2; beats[3] = 8'hC3;
    stream(4, 3, 1'b0, p0, na);
    check_eq("t1_accepted", na, 4);
    settle("t1");
    check_writes("t1", 4, p0, 1);
    check_eq("t1_ce_count", ce_c.size(), 1);
    if (ce_c.size() > 0) check_eq("t1_ce_latency", ce_c[0] - p0, 5);
    check_eq("t1_msg_len", msg_len, 3);
    check_eq("t1_err", err, 0);

    // Zero-length message.
    clr();
    do_en();
    beats[0] = 8'h00;
    stream(1, 0, 1'b0, p0, na);
    settle("t2");
    check_writes("t2", 1, p0, 1);
    check_eq("t2_ce_count", ce_c.size(), 1);
    if (ce_c.size() > 0) check_eq("t2_ce_latency", ce_c[0] - p0, 2);
    check_eq("t2_msg_len", msg_len, 0);

    // Short message: last arrives early.
    clr();
    do_en();
    beats[0] = 8'h04; beats[1] = 8'h11; beats[2] = 8'h22;
    stream(3, 2, 1'b0, p0, na);
    @(negedge clk);
    check_eq("t3_err_set", err, 1);
    check_eq("t3_rdy_low", rdy, 0);
    @(negedge clk);
    check_eq("t3_rdy_back", rdy, 1);
    check_eq("t3_err_sticky", err, 1);
    @(posedge clk); #1;
    check_writes("t3", 3, p0, 1);
    check_eq("t3_ce_count", ce_c.size(), 0);

    // Long message: no last on the final expected byte.
    clr();
    do_en();
    check_eq("t4_err_cleared", err, 0);
    beats[0] = 8'h02; beats[1] = 8'h11; beats[2] = 8'h22; beats[3] = 8'h33;
    stream(4, -1, 1'b0, p0, na);
    check_eq("t4_accepted", na, 3);
    check_eq("t4_err", err, 1);
    settle("t4");
    check_writes("t4", 3, p0, 1);
    check_eq("t4_ce_count", ce_c.size(), 0);

    // Gapped stream: valid toggles every cycle.
    clr();
    do_en();
    beats[0] = 8'h05; beats[1] = 8'h10; beats[2] = 8'h20;
    beats[3] = 8'h30; beats[4] = 8'h40; beats[5] = 8'h50;
    stream(6, 5, 1'b1, p0, na);
    settle("t5");
    check_writes("t5", 6, p0, 2);
    check_eq("t5_ce_count", ce_c.size(), 1);
    check_eq("t5_msg_len", msg_len, 5);

    // Reset in the middle of DATA.
    clr();
    do_en();
    beats[0] = 8'h05; beats[1] = 8'h01; beats[2] = 8'h02;
    stream(3, -1, 1'b0, p0, na);
    in_valid = 1'b1; in_data = 8'h03;
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rdy", rdy, 1);
    check_eq("t6_in_ready", in_ready, 0);
    check_eq("t6_wren", ct_wren, 0);
    check_eq("t6_addr", ct_addr, 0);
    check_eq("t6_wrdata", ct_wrdata, 0);
    check_eq("t6_msg_len", msg_len, 0);
    check_eq("t6_err", err, 0);
    check_eq("t6_crack_en", crack_en, 0);
    in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t6_no_ce", ce_c.size(), 0);
    clr();
    do_en();
    beats[0] = 8'h03; beats[1] = 8'hA1; beats[2] = 8'hB2; beats[3] = 8'hC3;
    stream(4, 3, 1'b0, p0, na);
    settle("t6b");
    check_writes("t6b", 4, p0, 1);
    check_eq("t6b_ce_count", ce_c.size(), 1);
    check_eq("t6b_msg_len", msg_len, 3);

    // Cracker busy: start pulse held off until crack_rdy rises.
    clr();
    hold = 1'b1;
    do_en();
    beats[0] = 8'h02; beats[1] = 8'h5A; beats[2] = 8'hA5;
    stream(3, 2, 1'b0, p0, na);
    repeat (20) @(posedge clk);
    #1;
    check_eq("t7_held_off", ce_c.size(), 0);
    hold = 1'b0;
    k = cyc;
    settle("t7");
    check_eq("t7_ce_count", ce_c.size(), 1);
    if (ce_c.size() > 0) check_eq("t7_ce_cycle", ce_c[0], k + 1);
    check_writes("t7", 3, p0, 1);

    // Bytes offered while idle are never consumed.
    clr();
    drive_beat(8'h77, 1'b1, acc, pc);
    check_eq("t8_idle_no_accept", acc, 0);
    @(negedge clk);
    check_eq("t8_no_write", wr_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
